// File: rtl/mem_line_responder.sv
// -----------------------------------------------------------------------------
// mem_line_responder
//
// Memory-side responder for the 256-bit cache-line request interface driven by
// the D-cache controller. It accepts one line read or line write per request,
// stores lines in an internal array, and answers with a one-cycle mem_ready
// pulse after a fixed, per-direction latency. Only one request is in flight
// at a time.
//
// Handshake: the initiator raises mem_valid with mem_addr/mem_rw/mem_wr and
// holds mem_valid high until it sees mem_ready. The request is latched on the
// capture edge, so later changes to mem_addr/mem_rw/mem_wr are ignored.
// Dropping mem_valid before mem_ready aborts the request with no side effects.
// mem_ready is high for exactly one cycle, in the cycle that follows the Nth
// rising edge after the capture edge (N = READ_LATENCY or WRITE_LATENCY).
//
// Ports:
//   clk        in   1           clock, rising edge
//   rst_n      in   1           asynchronous active-low reset
//   mem_addr   in   ADDR_WIDTH  line address; index = mem_addr[DEPTH_LOG2+2:3]
//   mem_wr     in   BLOCK_SIZE  write line data
//   mem_rw     in   1           1 = write, 0 = read
//   mem_valid  in   1           request present
//   mem_rd     out  BLOCK_SIZE  read line data (only during the ready cycle)
//   mem_ready  out  1           one-cycle completion pulse
//   rd_count   out  32          completed reads  (0 unless MEM_RESP_STATS_EN)
//   wr_count   out  32          completed writes (0 unless MEM_RESP_STATS_EN)
//
// Optional build macro: MEM_RESP_STATS_EN adds wrapping 32-bit completion
// counters. Without it, rd_count/wr_count are tied to zero.
// -----------------------------------------------------------------------------
module mem_line_responder #(
    parameter int ADDR_WIDTH    = 28,
    parameter int BLOCK_SIZE    = 256,
    parameter int DEPTH_LOG2    = 10,
    parameter int READ_LATENCY  = 4,
    parameter int WRITE_LATENCY = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [BLOCK_SIZE-1:0] mem_wr,
    input  logic                  mem_rw,
    input  logic                  mem_valid,
    output logic [BLOCK_SIZE-1:0] mem_rd,
    output logic                  mem_ready,
    output logic [31:0]           rd_count,
    output logic [31:0]           wr_count
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [7:0] RD_LAT_M1 = 8'(READ_LATENCY - 1);
    localparam logic [7:0] WR_LAT_M1 = 8'(WRITE_LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                  state;
    logic [7:0]              lat_cnt;
    logic [DEPTH_LOG2-1:0]   req_idx;
    logic                    req_rw;
    logic [BLOCK_SIZE-1:0]   req_data;
    logic                    rd_hit;     // RESP of a read whose line has been written
    logic [BLOCK_SIZE-1:0]   rd_line;    // array read data, captured on RESP entry
    logic [DEPTH-1:0]        written;    // per-line written-bit, cleared by reset
    logic [BLOCK_SIZE-1:0]   line_mem [DEPTH];
    logic                    resp_go;

    // Tag bits above the index and the byte offset below it do not select a line.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{mem_addr[2:0], mem_addr[ADDR_WIDTH-1:DEPTH_LOG2+3]};

    // The edge that moves WAIT -> RESP: request still valid and latency expired.
    assign resp_go = (state == WAIT) && mem_valid && (lat_cnt == 8'd0);

    // Line storage has no reset so it can map onto block RAM; the written-bit
    // array is what makes unwritten lines read back as zero.
    always_ff @(posedge clk) begin
        if (resp_go && req_rw) begin
            line_mem[req_idx] <= req_data;
        end
        if (resp_go) begin
            rd_line <= line_mem[req_idx];
        end
    end

    // A latency of 1 still spends one cycle in WAIT with lat_cnt = 0, so the
    // ready pulse always follows the Nth edge after capture for every N >= 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            lat_cnt   <= 8'd0;
            req_idx   <= '0;
            req_rw    <= 1'b0;
            req_data  <= '0;
            mem_ready <= 1'b0;
            rd_hit    <= 1'b0;
            written   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    mem_ready <= 1'b0;
                    rd_hit    <= 1'b0;
                    if (mem_valid) begin
                        req_idx  <= mem_addr[DEPTH_LOG2+2:3];
                        req_rw   <= mem_rw;
                        req_data <= mem_wr;
                        lat_cnt  <= mem_rw ? WR_LAT_M1 : RD_LAT_M1;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (!mem_valid) begin
                        // Abort: nothing is written, nothing is counted.
                        lat_cnt <= 8'd0;
                        state   <= IDLE;
                    end else if (lat_cnt == 8'd0) begin
                        mem_ready <= 1'b1;
                        state     <= RESP;
                        if (req_rw) begin
                            written[req_idx] <= 1'b1;
                            rd_hit           <= 1'b0;
                        end else begin
                            rd_hit <= written[req_idx];
                        end
                    end else begin
                        lat_cnt <= lat_cnt - 8'd1;
                    end
                end
                RESP: begin
                    mem_ready <= 1'b0;
                    rd_hit    <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    mem_ready <= 1'b0;
                    rd_hit    <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

    assign mem_rd = rd_hit ? rd_line : '0;

`ifdef MEM_RESP_STATS_EN
    logic [31:0] rd_cnt_q;
    logic [31:0] wr_cnt_q;

    // Counted on the edge entering RESP so the new value is visible alongside
    // mem_ready; natural 32-bit overflow gives the wrap to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_cnt_q <= 32'd0;
            wr_cnt_q <= 32'd0;
        end else if (resp_go) begin
            if (req_rw) begin
                wr_cnt_q <= wr_cnt_q + 32'd1;
            end else begin
                rd_cnt_q <= rd_cnt_q + 32'd1;
            end
        end
    end

    assign rd_count = rd_cnt_q;
    assign wr_count = wr_cnt_q;
`else
    assign rd_count = 32'd0;
    assign wr_count = 32'd0;
`endif

endmodule

// File: tb/tb_mem_line_responder.sv
// -----------------------------------------------------------------------------
// tb_mem_line_responder
//
// Self-checking bench for mem_line_responder: reset values, a table of
// directed requests, hand-written abort / mid-request reset / latched-request /
// burst sequences, and randomized requests checked against a line-array model
// keyed by line index.
// -----------------------------------------------------------------------------
module tb_mem_line_responder;

    localparam int AW  = 28;
    localparam int BW  = 256;
    localparam int DL2 = 10;
    localparam int RL  = 4;
    localparam int WL  = 4;
`ifdef MEM_RESP_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] mem_addr = '0;
    logic [BW-1:0] mem_wr = '0;
    logic          mem_rw = 1'b0;
    logic          mem_valid = 1'b0;
    logic [BW-1:0] mem_rd;
    logic          mem_ready;
    logic [31:0]   rd_count;
    logic [31:0]   wr_count;

    always #5 clk = ~clk;

    mem_line_responder #(
        .ADDR_WIDTH   (AW),
        .BLOCK_SIZE   (BW),
        .DEPTH_LOG2   (DL2),
        .READ_LATENCY (RL),
        .WRITE_LATENCY(WL)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .mem_addr (mem_addr),
        .mem_wr   (mem_wr),
        .mem_rw   (mem_rw),
        .mem_valid(mem_valid),
        .mem_rd   (mem_rd),
        .mem_ready(mem_ready),
        .rd_count (rd_count),
        .wr_count (wr_count)
    );

    // ---------------- scoreboard / model ----------------
    int          checks = 0;
    int          errors = 0;
    logic [BW-1:0] model_mem [int];   // written lines only, keyed by line index
    logic [31:0] exp_rd_cnt = 32'd0;
    logic [31:0] exp_wr_cnt = 32'd0;

    typedef struct {
        logic          rw;
        logic [AW-1:0] addr;
        logic [BW-1:0] data;
        bit            hold;
        int            exp_edges;
        logic [BW-1:0] exp_rd;
        string         name;
    } vec_t;

    vec_t vecs[8];

    localparam logic [BW-1:0] BEEF = {8{32'hDEAD_BEEF}};
    localparam logic [BW-1:0] PAT_A = {4{64'h0123_4567_89AB_CDEF}};
    localparam logic [BW-1:0] PAT_B = {8{32'h1234_5678}};

    task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int idx_of(input logic [AW-1:0] a);
        return int'(a[DL2+2:3]);
    endfunction

    function automatic logic [BW-1:0] model_read(input logic [AW-1:0] a);
        if (model_mem.exists(idx_of(a))) return model_mem[idx_of(a)];
        return '0;
    endfunction

    function automatic logic [BW-1:0] rand_line();
        logic [BW-1:0] v;
        for (int i = 0; i < BW / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [31:0] cnt_exp(input logic [31:0] c);
        return STATS ? c : 32'd0;
    endfunction

    // Bounded wait for mem_ready; returns number of edges taken.
    task automatic wait_ready(output int edges);
        edges = 0;
        do begin
            tick();
            edges++;
        end while (!mem_ready && edges < 300);
    endtask

    // Checks made in the ready cycle and, if the request is not held, the
    // cycle after it.
    task automatic check_resp(input logic rw, input logic [BW-1:0] exp_rd,
                              input bit hold, input string name);
        check({name, "_rd"}, mem_rd, exp_rd);
        if (rw) exp_wr_cnt++;
        else    exp_rd_cnt++;
        check({name, "_rd_count"}, BW'(rd_count), BW'(cnt_exp(exp_rd_cnt)));
        check({name, "_wr_count"}, BW'(wr_count), BW'(cnt_exp(exp_wr_cnt)));
        if (!hold) begin
            mem_valid = 1'b0;
            tick();
            check({name, "_ready_width"}, BW'(mem_ready), BW'(1'b0));
            check({name, "_rd_after"}, mem_rd, '0);
        end
    endtask

    // ---------------- driver ----------------
    task automatic req(input logic rw, input logic [AW-1:0] addr, input logic [BW-1:0] data,
                       input bit hold, input int exp_edges, input logic [BW-1:0] exp_rd,
                       input string name);
        int edges;
        mem_rw    = rw;
        mem_addr  = addr;
        mem_wr    = data;
        mem_valid = 1'b1;
        wait_ready(edges);
        check({name, "_latency"}, BW'(edges), BW'(exp_edges));
        if (!mem_ready) begin
            mem_valid = 1'b0;
            tick();
            tick();
            return;
        end
        if (rw) model_mem[idx_of(addr)] = data;
        check_resp(rw, exp_rd, hold, name);
    endtask

    // ---------------- test ----------------
    initial begin
        int            edges;
        bit            prev_hold;
        logic [AW-1:0] a;
        logic [BW-1:0] d;
        logic          rw;
        bit            hold;

        // Reset state
        tick();
        check("reset_ready", BW'(mem_ready), BW'(1'b0));
        check("reset_rd", mem_rd, '0);
        check("reset_rd_count", BW'(rd_count), '0);
        check("reset_wr_count", BW'(wr_count), '0);
        tick();
        rst_n = 1'b1;
        tick();

        // Directed table
        vecs[0] = '{1'b0, 28'h0000010, '0,    1'b0, RL + 1, '0,    "rd_unwritten"};
        vecs[1] = '{1'b1, 28'h0000100, BEEF,  1'b1, WL + 1, '0,    "wr_100"};
        vecs[2] = '{1'b0, 28'h0000100, '0,    1'b0, RL + 2, BEEF,  "rd_100_b2b"};
        vecs[3] = '{1'b1, 28'h0002008, PAT_A, 1'b0, WL + 1, '0,    "wr_alias"};
        vecs[4] = '{1'b0, 28'h0000008, '0,    1'b0, RL + 1, PAT_A, "rd_alias"};
        vecs[5] = '{1'b0, 28'hFFF2107, '0,    1'b0, RL + 1, BEEF,  "rd_tag_low"};
        vecs[6] = '{1'b1, 28'h0000100, PAT_B, 1'b0, WL + 1, '0,    "wr_100_new"};
        vecs[7] = '{1'b0, 28'h0000100, '0,    1'b0, RL + 1, PAT_B, "rd_100_new"};
        for (int i = 0; i < 8; i++) begin
            req(vecs[i].rw, vecs[i].addr, vecs[i].data, vecs[i].hold,
                vecs[i].exp_edges, vecs[i].exp_rd, vecs[i].name);
        end

        // Request is latched: changes during WAIT are ignored
        mem_rw = 1'b1; mem_addr = 28'h0000300; mem_wr = PAT_A; mem_valid = 1'b1;
        tick();
        mem_rw = 1'b0; mem_addr = 28'h0000308; mem_wr = ~PAT_A;
        wait_ready(edges);
        check("latched_latency", BW'(edges + 1), BW'(WL + 1));
        model_mem[idx_of(28'h0000300)] = PAT_A;
        check_resp(1'b1, '0, 1'b0, "latched");
        req(1'b0, 28'h0000300, '0, 1'b0, RL + 1, PAT_A, "latched_rd_orig");
        req(1'b0, 28'h0000308, '0, 1'b0, RL + 1, '0, "latched_rd_other");

        // Abort: valid dropped after 2 WAIT edges
        mem_rw = 1'b0; mem_addr = 28'h0000100; mem_valid = 1'b1;
        tick();
        tick();
        tick();
        mem_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("abort_no_ready", BW'(mem_ready), BW'(1'b0));
        end
        check("abort_rd_count", BW'(rd_count), BW'(cnt_exp(exp_rd_cnt)));
        req(1'b0, 28'h0000100, '0, 1'b0, RL + 1, PAT_B, "after_abort");

        // Reset during WAIT of a write to line 5
        mem_rw = 1'b1; mem_addr = 28'h0000028; mem_wr = PAT_A; mem_valid = 1'b1;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        mem_valid = 1'b0;
        check("midrst_ready", BW'(mem_ready), BW'(1'b0));
        check("midrst_rd", mem_rd, '0);
        check("midrst_wr_count", BW'(wr_count), '0);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("midrst_ready_held", BW'(mem_ready), BW'(1'b0));
        end
        rst_n = 1'b1;
        model_mem.delete();
        exp_rd_cnt = 32'd0;
        exp_wr_cnt = 32'd0;
        tick();
        req(1'b0, 28'h0000028, '0, 1'b0, RL + 1, '0, "midrst_rd_line5");
        req(1'b0, 28'h0000100, '0, 1'b0, RL + 1, '0, "midrst_rd_cleared");

        // Flush-style burst: 4 writes with valid held throughout
        for (int i = 0; i < 4; i++) begin
            a = AW'(28'h0000400 + 28'(i * 8));
            req(1'b1, a, rand_line(), (i != 3), (i == 0) ? WL + 1 : WL + 2, '0, "burst_wr");
        end
        check("burst_wr_count", BW'(wr_count), BW'(cnt_exp(32'd4)));
        for (int i = 0; i < 4; i++) begin
            a = AW'(28'h0000400 + 28'(i * 8));
            req(1'b0, a, '0, 1'b0, RL + 1, model_read(a), "burst_rd");
        end

        // Randomized requests against the line model
        prev_hold = 1'b0;
        for (int i = 0; i < 40; i++) begin
            rw   = 1'($urandom_range(0, 1));
            a    = AW'($urandom);
            a[DL2+2:3] = DL2'($urandom_range(0, 15));
            d    = rand_line();
            hold = (i == 39) ? 1'b0 : 1'($urandom_range(0, 1));
            req(rw, a, d, hold, (rw ? WL : RL) + 1 + (prev_hold ? 1 : 0),
                rw ? '0 : model_read(a), "random");
            prev_hold = hold;
        end

        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
